// File: rtl/audio_pkg.sv
// Shared constants, FSM state type and gain ramp helper for the audio volume stage.
package audio_pkg;

   localparam int SAMPLE_W   = 24;
   localparam int GAIN_W     = 8;
   localparam int GAIN_SHIFT = 7;
   localparam int RAMP_STEP  = 1;
   localparam int UNITY_GAIN = 128;
   localparam int PROD_W     = SAMPLE_W + GAIN_W + 1;

   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      SAT   = 2'd2,
      WRITE = 2'd3
   } state_t;

   // Moves cur toward target by at most RAMP_STEP; lands exactly on target, never wraps.
   function automatic logic [GAIN_W-1:0] ramp_gain(input logic [GAIN_W-1:0] cur,
                                                   input logic [GAIN_W-1:0] target);
      logic [GAIN_W-1:0] step;
      logic [GAIN_W-1:0] diff;
      step = GAIN_W'(RAMP_STEP);
      if (target > cur) begin
         diff      = target - cur;
         ramp_gain = (diff < step) ? target : cur + step;
      end else begin
         diff      = cur - target;
         ramp_gain = (diff < step) ? target : cur - step;
      end
   endfunction

endpackage

// File: rtl/audio_sat_scale.sv
// One audio channel: sample latch, registered signed multiply by an unsigned
// gain, then arithmetic shift and saturation to the sample width.
module audio_sat_scale
   import audio_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ld_en,
   input  logic                mul_en,
   input  logic                sat_en,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic [GAIN_W-1:0]   gain,
   output logic [SAMPLE_W-1:0] sample_out
);

   localparam logic signed [PROD_W-1:0] LIM_HI = {{(PROD_W-SAMPLE_W){1'b0}}, SAMPLE_MAX};
   localparam logic signed [PROD_W-1:0] LIM_LO = {{(PROD_W-SAMPLE_W){1'b1}}, SAMPLE_MIN};

   logic signed [SAMPLE_W-1:0] sample_q;
   logic signed [PROD_W-1:0]   sample_ext;
   logic signed [PROD_W-1:0]   gain_ext;
   logic signed [PROD_W-1:0]   product_q;
   logic signed [PROD_W-1:0]   shifted;
   logic        [SAMPLE_W-1:0] sat_val;

   // Gain is unsigned, so it is zero-extended; the sample keeps its sign.
   assign sample_ext = {{(PROD_W-SAMPLE_W){sample_q[SAMPLE_W-1]}}, sample_q};
   assign gain_ext   = {{(PROD_W-GAIN_W){1'b0}}, gain};
   assign shifted    = product_q >>> GAIN_SHIFT;

   // Clamp the shifted product into the signed sample range.
   always_comb begin
      sat_val = shifted[SAMPLE_W-1:0];
      if (shifted > LIM_HI) begin
         sat_val = SAMPLE_MAX;
      end else if (shifted < LIM_LO) begin
         sat_val = SAMPLE_MIN;
      end
   end

   // Pipeline registers, each advanced only by its FSM enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_q   <= '0;
         product_q  <= '0;
         sample_out <= '0;
      end else begin
         if (ld_en) begin
            sample_q <= sample_in;
         end
         if (mul_en) begin
            product_q <= sample_ext * gain_ext;
         end
         if (sat_en) begin
            sample_out <= sat_val;
         end
      end
   end

endmodule

// File: rtl/audio_volume_stage.sv
// Audio volume stage: pops a stereo frame from the CODEC ADC FIFO, scales it by
// a smoothed gain that ramps toward the dial setting, pushes it to the DAC FIFO.
// Optional soft mute (adds a mute input) is built when AUDIO_VOLUME_SOFT_MUTE_EN is defined.
//
// state | meaning
// IDLE  | waiting for a frame and DAC space; pops and latches the frame
// MUL   | multiply both samples by cur_gain
// SAT   | shift and saturate into writedata_*
// WRITE | push when the DAC FIFO has space; step cur_gain on the push
module audio_volume_stage
   import audio_pkg::*;
(
   input  logic                CLOCK_50,
   input  logic                reset_n,
`ifdef AUDIO_VOLUME_SOFT_MUTE_EN
   input  logic                mute,
`endif
   input  logic [GAIN_W-1:0]   dial,
   input  logic                read_ready,
   input  logic                write_ready,
   input  logic [SAMPLE_W-1:0] readdata_left,
   input  logic [SAMPLE_W-1:0] readdata_right,
   output logic                read,
   output logic                write,
   output logic [SAMPLE_W-1:0] writedata_left,
   output logic [SAMPLE_W-1:0] writedata_right,
   output logic [GAIN_W-1:0]   cur_gain
);

   state_t            state;
   state_t            state_nxt;
   logic [GAIN_W-1:0] dial_q;
   logic [GAIN_W-1:0] target;
   logic              ld_en;
   logic              mul_en;
   logic              sat_en;

`ifdef AUDIO_VOLUME_SOFT_MUTE_EN
   assign target = mute ? '0 : dial_q;
`else
   assign target = dial_q;
`endif

   // State register.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake strobes; read is held off while reset is asserted.
   always_comb begin
      state_nxt = state;
      read      = 1'b0;
      write     = 1'b0;
      ld_en     = 1'b0;
      mul_en    = 1'b0;
      sat_en    = 1'b0;
      unique case (state)
         IDLE: begin
            if (reset_n && read_ready && write_ready) begin
               read      = 1'b1;
               ld_en     = 1'b1;
               state_nxt = MUL;
            end
         end
         MUL: begin
            mul_en    = 1'b1;
            state_nxt = SAT;
         end
         SAT: begin
            sat_en    = 1'b1;
            state_nxt = WRITE;
         end
         WRITE: begin
            if (write_ready) begin
               write     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Dial is resampled every cycle; the gain only moves once per pushed frame.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         dial_q   <= '0;
         cur_gain <= '0;
      end else begin
         dial_q <= dial;
         if (write) begin
            cur_gain <= ramp_gain(cur_gain, target);
         end
      end
   end

   audio_sat_scale u_scale_left (
      .clk        (CLOCK_50),
      .rst_n      (reset_n),
      .ld_en      (ld_en),
      .mul_en     (mul_en),
      .sat_en     (sat_en),
      .sample_in  (readdata_left),
      .gain       (cur_gain),
      .sample_out (writedata_left)
   );

   audio_sat_scale u_scale_right (
      .clk        (CLOCK_50),
      .rst_n      (reset_n),
      .ld_en      (ld_en),
      .mul_en     (mul_en),
      .sat_en     (sat_en),
      .sample_in  (readdata_right),
      .gain       (cur_gain),
      .sample_out (writedata_right)
   );

endmodule

// File: tb/tb_audio_volume_stage.sv
// Bench for audio_volume_stage: frame-level model checked every cycle plus
// hand-computed literal expectations for the notable operating points.
module tb_audio_volume_stage;

   localparam int RAMP = 1;

   logic        clk;
   logic        reset_n;
   logic [7:0]  dial;
   logic        read_ready;
   logic        write_ready;
   logic [23:0] rd_l;
   logic [23:0] rd_r;
   logic        read;
   logic        write;
   logic [23:0] wd_l;
   logic [23:0] wd_r;
   logic [7:0]  cur_gain;
`ifdef AUDIO_VOLUME_SOFT_MUTE_EN
   logic        mute;
   initial mute = 1'b0;
`endif

   int errors = 0;
   int checks = 0;
   int nwrites = 0;

   audio_volume_stage dut (
      .CLOCK_50        (clk),
      .reset_n         (reset_n),
`ifdef AUDIO_VOLUME_SOFT_MUTE_EN
      .mute            (mute),
`endif
      .dial            (dial),
      .read_ready      (read_ready),
      .write_ready     (write_ready),
      .readdata_left   (rd_l),
      .readdata_right  (rd_r),
      .read            (read),
      .write           (write),
      .writedata_left  (wd_l),
      .writedata_right (wd_r),
      .cur_gain        (cur_gain)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scaled sample: sample * gain / 128 rounded toward minus infinity, clamped to 24-bit signed.
   function automatic logic [23:0] scale(input logic [23:0] s, input int g);
      longint v;
      v = longint'($signed(s)) * longint'(g);
      v = v >>> 7;
      if (v > 64'sd8388607)  v = 64'sd8388607;
      if (v < -64'sd8388608) v = -64'sd8388608;
      return v[23:0];
   endfunction

   // Frame-level reference: at most one frame in flight, gain steps once per push.
   int          m_gain = 0;
   int          m_dq   = 0;
   bit          m_busy = 0;
   int          m_age  = 0;
   logic [23:0] m_l = '0;
   logic [23:0] m_r = '0;
   bit          exp_read;
   bit          exp_write;

   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_read", read, 0);
         chk("rst_write", write, 0);
         chk("rst_wd_l", wd_l, 0);
         chk("rst_wd_r", wd_r, 0);
         chk("rst_gain", cur_gain, 0);
         m_busy = 0;
         m_age  = 0;
         m_gain = 0;
         m_dq   = 0;
      end else begin
         exp_read  = !m_busy && read_ready && write_ready;
         exp_write = m_busy && (m_age >= 3) && write_ready;
         chk("read", read, exp_read);
         chk("write", write, exp_write);
         chk("cur_gain", cur_gain, m_gain);
         if (m_busy && m_age >= 3) begin
            chk("wd_l", wd_l, m_l);
            chk("wd_r", wd_r, m_r);
         end
         if (exp_write) begin
            m_busy = 0;
            nwrites++;
            if (m_dq > m_gain)      m_gain += (m_dq - m_gain < RAMP) ? (m_dq - m_gain) : RAMP;
            else if (m_dq < m_gain) m_gain -= (m_gain - m_dq < RAMP) ? (m_gain - m_dq) : RAMP;
         end else if (m_busy) begin
            m_age++;
         end
         if (exp_read) begin
            m_busy = 1;
            m_age  = 1;
            m_l    = scale(rd_l, m_gain);
            m_r    = scale(rd_r, m_gain);
         end
         m_dq = int'(dial);
      end
   end

   // One complete frame: offer it, wait for the pop, then wait for the push.
   task automatic frame(input logic [23:0] l, input logic [23:0] r,
                        output logic [23:0] ol, output logic [23:0] orr);
      bit got;
      ol  = '0;
      orr = '0;
      @(posedge clk); #1;
      rd_l = l;
      rd_r = r;
      read_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (read) got = 1;
      end
      chk("read_seen", got, 1);
      @(posedge clk); #1;
      read_ready = 1'b0;
      rd_l = ~l;
      rd_r = ~r;
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (write) begin
            got = 1;
            ol  = wd_l;
            orr = wd_r;
         end
      end
      chk("write_seen", got, 1);
   endtask

   task automatic frames(input int n, input logic [23:0] base);
      logic [23:0] ol, orr, l;
      for (int i = 0; i < n; i++) begin
         l = base + 24'(i * 24'h01357);
         frame(l, ~l, ol, orr);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [23:0] ol, orr;
      bit got;
      reset_n     = 1'b0;
      dial        = 8'd0;
      read_ready  = 1'b0;
      write_ready = 1'b1;
      rd_l        = '0;
      rd_r        = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_gain_lit", cur_gain, 0);
      chk("reset_wd_lit", wd_l, 0);
      reset_n = 1'b1;
      dial    = 8'd128;

      // Fade-in to unity over 128 frames, 200 frames total.
      for (int i = 0; i < 200; i++) frame(24'h001000, 24'hFFF800, ol, orr);
      @(posedge clk); #1;
      chk("unity_left", ol, 24'h001000);
      chk("unity_right", orr, 24'hFFF800);
      chk("unity_gain", cur_gain, 128);
      chk("write_count", nwrites, 200);

      // Ramp up to full gain, then saturate both rails.
      dial = 8'd255;
      frames(127, 24'h012345);
      @(posedge clk); #1;
      chk("gain_255", cur_gain, 255);
      frame(24'h7FF000, 24'h800100, ol, orr);
      chk("clamp_hi", ol, 24'h7FFFFF);
      chk("clamp_lo", orr, 24'h800000);

      // Settle at 200, then step down to 10.
      dial = 8'd200;
      frames(55, 24'hF00010);
      @(posedge clk); #1;
      chk("gain_200", cur_gain, 200);
      dial = 8'd10;
      frames(189, 24'h0A0A0A);
      @(posedge clk); #1;
      chk("gain_11", cur_gain, 11);
      frames(1, 24'h000777);
      @(posedge clk); #1;
      chk("gain_10", cur_gain, 10);
      frames(1, 24'h000777);
      @(posedge clk); #1;
      chk("gain_10_hold", cur_gain, 10);

      // Half gain on a negative sample keeps the sign.
      dial = 8'd64;
      frames(54, 24'h3C0000);
      @(posedge clk); #1;
      chk("gain_64", cur_gain, 64);
      frame(24'hFFFF00, 24'h000100, ol, orr);
      chk("neg_half_left", ol, 24'hFFFF80);
      chk("pos_half_right", orr, 24'h000080);

      // DAC back-pressure: hold write_ready low after the pop.
      @(posedge clk); #1;
      rd_l = 24'h000400;
      rd_r = 24'h000100;
      read_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (read) got = 1;
      end
      chk("stall_read_seen", got, 1);
      @(posedge clk); #1;
      write_ready = 1'b0;
      repeat (12) @(negedge clk);
      chk("stall_write_low", write, 0);
      chk("stall_wd_l", wd_l, 24'h000200);
      chk("stall_wd_r", wd_r, 24'h000080);
      @(posedge clk); #1;
      read_ready  = 1'b0;
      write_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_write", write, 1);

      // Reset while the frame is in MUL.
      @(posedge clk); #1;
      read_ready = 1'b1;
      @(negedge clk);
      chk("mulrst_pop", read, 1);
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk("mulrst_read", read, 0);
      chk("mulrst_write", write, 0);
      chk("mulrst_wd_l", wd_l, 0);
      chk("mulrst_wd_r", wd_r, 0);
      chk("mulrst_gain", cur_gain, 0);
      read_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_no_read", read, 0);
      frame(24'h000100, 24'hFFFF00, ol, orr);
      chk("post_rst_silent", ol, 0);
      @(posedge clk); #1;
      chk("post_rst_gain", cur_gain, 1);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
